// File: rtl/rf_pkg.sv
// Shared defaults for the multiport register file.
// Width, depth and zero-register policy live here.
package rf_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 4;
    localparam int ZERO_REG_DEF = 0;

endpackage

// File: rtl/multiport_reg_file_if.sv
// Port bundle for the register file: enable, two write ports,
// one reserve port and two read ports.
interface multiport_reg_file_if
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              En;
    logic              Wr0En;
    logic [ADDR_W-1:0] Wr0Addr;
    logic [DATA_W-1:0] Wr0Data;
    logic              Wr1En;
    logic [ADDR_W-1:0] Wr1Addr;
    logic [DATA_W-1:0] Wr1Data;
    logic              ResEn;
    logic [ADDR_W-1:0] ResAddr;
    logic [ADDR_W-1:0] RdAddrA;
    logic [ADDR_W-1:0] RdAddrB;
    logic [DATA_W-1:0] RdDataA;
    logic [DATA_W-1:0] RdDataB;
    logic              PendA;
    logic              PendB;

    modport master (
        output En,
        output Wr0En, Wr0Addr, Wr0Data,
        output Wr1En, Wr1Addr, Wr1Data,
        output ResEn, ResAddr,
        output RdAddrA, RdAddrB,
        input  RdDataA, RdDataB,
        input  PendA, PendB
    );

    modport slave (
        input  En,
        input  Wr0En, Wr0Addr, Wr0Data,
        input  Wr1En, Wr1Addr, Wr1Data,
        input  ResEn, ResAddr,
        input  RdAddrA, RdAddrB,
        output RdDataA, RdDataB,
        output PendA, PendB
    );

endinterface

// File: rtl/multiport_reg_file_read_port.sv
// One registered read port: compares against this cycle's commits
// so the output shows the post-edge register and pending state.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [ADDR_W-1:0]                addr,
    input  logic                             w0,
    input  logic [ADDR_W-1:0]                w0_addr,
    input  logic [DATA_W-1:0]                w0_data,
    input  logic                             w1,
    input  logic [ADDR_W-1:0]                w1_addr,
    input  logic [DATA_W-1:0]                w1_data,
    input  logic                             res,
    input  logic [ADDR_W-1:0]                res_addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              pend,
    output logic [DATA_W-1:0]                data,
    output logic                             pend_out
);

    logic              hit0;
    logic              hit1;
    logic              hitr;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_pend;

    always_comb begin
        hit0     = w0 && (w0_addr == addr);
        hit1     = w1 && (w1_addr == addr);
        hitr     = res && (res_addr == addr);
        nxt_data = regs[addr];
        nxt_pend = pend[addr];
        if (hit1) begin
            nxt_data = w1_data;
        end else if (hit0) begin
            nxt_data = w0_data;
        end
        // a same-cycle reserve outranks the clear from a write
        if (hitr) begin
            nxt_pend = 1'b1;
        end else if (hit0 || hit1) begin
            nxt_pend = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data     <= '0;
            pend_out <= 1'b0;
        end else if (en) begin
            data     <= nxt_data;
            pend_out <= nxt_pend;
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Two-write, two-read register file with per-register pending bits
// and write-through read bypass.
module multiport_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input logic                 Clk,
    input logic                 Rst,
    multiport_reg_file_if.slave bus
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                            w0;
    logic                            w1;
    logic                            res;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             pend;

    function automatic logic zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // commit flags: discarded traffic to a hardwired zero never commits
    assign w0  = bus.En && bus.Wr0En && !zero_addr(bus.Wr0Addr);
    assign w1  = bus.En && bus.Wr1En && !zero_addr(bus.Wr1Addr);
    assign res = bus.En && bus.ResEn && !zero_addr(bus.ResAddr);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign regs[i] = '0;
            assign pend[i] = 1'b0;
        end else begin : g_store
            logic [DATA_W-1:0] q;
            logic              p;
            logic              hit0;
            logic              hit1;
            logic              hitr;

            assign hit0 = w0 && (bus.Wr0Addr == ADDR_W'(i));
            assign hit1 = w1 && (bus.Wr1Addr == ADDR_W'(i));
            assign hitr = res && (bus.ResAddr == ADDR_W'(i));

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    q <= '0;
                    p <= 1'b0;
                end else begin
                    if (hit1) begin
                        q <= bus.Wr1Data;
                    end else if (hit0) begin
                        q <= bus.Wr0Data;
                    end
                    if (hitr) begin
                        p <= 1'b1;
                    end else if (hit0 || hit1) begin
                        p <= 1'b0;
                    end
                end
            end

            assign regs[i] = q;
            assign pend[i] = p;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_a (
        .clk      (Clk),
        .rst      (Rst),
        .en       (bus.En),
        .addr     (bus.RdAddrA),
        .w0       (w0),
        .w0_addr  (bus.Wr0Addr),
        .w0_data  (bus.Wr0Data),
        .w1       (w1),
        .w1_addr  (bus.Wr1Addr),
        .w1_data  (bus.Wr1Data),
        .res      (res),
        .res_addr (bus.ResAddr),
        .regs     (regs),
        .pend     (pend),
        .data     (bus.RdDataA),
        .pend_out (bus.PendA)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_b (
        .clk      (Clk),
        .rst      (Rst),
        .en       (bus.En),
        .addr     (bus.RdAddrB),
        .w0       (w0),
        .w0_addr  (bus.Wr0Addr),
        .w0_data  (bus.Wr0Data),
        .w1       (w1),
        .w1_addr  (bus.Wr1Addr),
        .w1_data  (bus.Wr1Data),
        .res      (res),
        .res_addr (bus.ResAddr),
        .regs     (regs),
        .pend     (pend),
        .data     (bus.RdDataB),
        .pend_out (bus.PendB)
    );

endmodule
